// File: rtl/isa_pkg.sv
// Shared definitions for the ISA datapath and its program sequencer:
// instruction field positions, bus widths and the sequencer state encoding.
package isa_pkg;

  localparam int INSTR_W = 21;
  localparam int DATA_W  = 32;

  localparam int OP1_HI     = 20;
  localparam int OP1_LO     = 16;
  localparam int OP2_HI     = 15;
  localparam int OP2_LO     = 11;
  localparam int WE_BR_BIT  = 10;
  localparam int ALU_OP_HI  = 9;
  localparam int ALU_OP_LO  = 7;
  localparam int DIR_RAM_HI = 6;
  localparam int DIR_RAM_LO = 2;
  localparam int WE_RAM_BIT = 1;
  localparam int HALT_BIT   = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/isa_secuenciador.sv
// Program sequencer: fetches instruction words from a synchronous ROM, presents
// each to the ISA datapath for HOLD_CYC cycles and captures results of reads.
module isa_secuenciador #(
  parameter int INSTR_W    = isa_pkg::INSTR_W,
  parameter int DATA_W     = isa_pkg::DATA_W,
  parameter int PROG_DEPTH = 21,
  parameter int ADDR_W     = 5,
  parameter int HOLD_CYC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inicio,
  input  logic               abortar,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instruccion,
  input  logic [DATA_W-1:0]  salida,
  output logic [DATA_W-1:0]  dato_leido,
  output logic               dato_valido,
  output logic               ocupado,
  output logic               fin
);

  import isa_pkg::*;

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [INSTR_W-1:0]  word, word_n;
  logic [DATA_W-1:0]   leido_n;
  logic                valido_n;

  always_ff @(posedge clk) begin
    if (rst || abortar) begin
      state       <= IDLE;
      pc          <= '0;
      cnt         <= '0;
      word        <= '0;
      dato_leido  <= '0;
      dato_valido <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      cnt         <= cnt_n;
      word        <= word_n;
      dato_leido  <= leido_n;
      dato_valido <= valido_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    cnt_n    = cnt;
    word_n   = word;
    leido_n  = dato_leido;
    valido_n = 1'b0;
    case (state)
      IDLE: begin
        if (inicio) begin
          state_n = FETCH;
          pc_n    = '0;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        word_n  = rom_data;
        cnt_n   = CNT_LOAD;
        state_n = HOLD;
      end
      HOLD: begin
        if (cnt == '0) begin
          if (!word[WE_RAM_BIT]) begin
            leido_n  = salida;
            valido_n = 1'b1;
          end
          // End check is against the last programmed entry, so pc never wraps.
          if (word[HALT_BIT] || (pc == LAST_PC)) begin
            state_n = DONE;
          end else begin
            pc_n    = pc + ADDR_W'(1);
            state_n = FETCH;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Write enables reach the datapath only while a word is being held,
  // so transitions between instructions can never cause a second write.
  always_comb begin
    instruccion = word;
    if (state != HOLD) begin
      instruccion[WE_BR_BIT]  = 1'b0;
      instruccion[WE_RAM_BIT] = 1'b0;
    end
  end

  assign rom_addr = pc;
  assign ocupado  = (state == FETCH) || (state == LOAD) || (state == HOLD);
  assign fin      = (state == DONE);

endmodule

// File: tb/tb_isa_secuenciador.sv
// Self-checking bench for isa_secuenciador: directed programs plus random ones,
// compared cycle by cycle against a trace built from the sequencing rules.
module tb_isa_secuenciador;

  localparam int IW    = 21;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 21;
  localparam int HOLD  = 4;

  logic           clk = 1'b0;
  logic           rst, inicio, abortar;
  logic [AW-1:0]  rom_addr;
  logic [IW-1:0]  rom_data, instruccion;
  logic [DW-1:0]  salida, dato_leido;
  logic           dato_valido, ocupado, fin;

  logic [IW-1:0]  rom [0:31];
  logic           sal_fixed;
  logic [DW-1:0]  sal_const;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
    logic          ocup;
    logic          fin;
    logic          valid;
    logic [DW-1:0] leido;
  } obs_t;

  obs_t          exp_q[$];
  logic [IW-1:0] mdl_word;
  logic [DW-1:0] mdl_leido;

  isa_secuenciador #(
    .INSTR_W(IW), .DATA_W(DW), .PROG_DEPTH(DEPTH), .ADDR_W(AW), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .abortar(abortar),
    .rom_addr(rom_addr), .rom_data(rom_data), .instruccion(instruccion),
    .salida(salida), .dato_leido(dato_leido), .dato_valido(dato_valido),
    .ocupado(ocupado), .fin(fin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Datapath stand-in: result is a fixed scramble of the presented word.
  always_comb salida = sal_fixed ? sal_const : ({11'h5A5, instruccion} ^ 32'h3C3C_0F0F);

  function automatic logic [DW-1:0] result_of(input logic [IW-1:0] w);
    return sal_fixed ? sal_const : ({11'h5A5, w} ^ 32'h3C3C_0F0F);
  endfunction

  function automatic logic [IW-1:0] gated(input logic [IW-1:0] w);
    logic [IW-1:0] r;
    r = w;
    r[10] = 1'b0;
    r[1]  = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic chk_obs(input int c, input obs_t e);
    chk($sformatf("c%0d rom_addr", c), 32'(rom_addr), 32'(e.addr));
    chk($sformatf("c%0d instruccion", c), 32'(instruccion), 32'(e.instr));
    chk($sformatf("c%0d ocupado", c), 32'(ocupado), 32'(e.ocup));
    chk($sformatf("c%0d fin", c), 32'(fin), 32'(e.fin));
    chk($sformatf("c%0d dato_valido", c), 32'(dato_valido), 32'(e.valid));
    chk($sformatf("c%0d dato_leido", c), dato_leido, e.leido);
  endtask

  // Expected trace from the cycle after inicio through DONE: each word costs
  // one fetch cycle, one load cycle and HOLD cycles of presentation.
  task automatic build(output int done_idx);
    obs_t          e;
    logic [IW-1:0] prev, w;
    logic [DW-1:0] leido;
    logic          pend;
    int            k;
    exp_q.delete();
    prev  = mdl_word;
    leido = mdl_leido;
    pend  = 1'b0;
    k     = 0;
    w     = '0;
    while (1) begin
      w = rom[k];
      e.addr = AW'(k); e.instr = gated(prev); e.ocup = 1'b1; e.fin = 1'b0;
      e.valid = pend; e.leido = leido;
      exp_q.push_back(e);
      pend = 1'b0;
      e.valid = 1'b0;
      exp_q.push_back(e);
      e.instr = w;
      for (int h = 0; h < HOLD; h++) exp_q.push_back(e);
      if (!w[1]) begin
        leido = result_of(w);
        pend  = 1'b1;
      end
      prev = w;
      if (w[0] || k == DEPTH - 1) break;
      k++;
    end
    e.addr = AW'(k); e.instr = gated(w); e.ocup = 1'b0; e.fin = 1'b1;
    e.valid = pend; e.leido = leido;
    exp_q.push_back(e);
    done_idx  = exp_q.size() - 1;
    mdl_word  = w;
    mdl_leido = leido;
  endtask

  // stop_c >= 0: abort (or 2-cycle rst when by_rst) issued in cycle stop_c.
  task automatic run(input int stop_c, input bit by_rst, input int ign_c,
                     input bit ign_done, input int idle_n);
    int   done_idx;
    obs_t e, idle_e, rst_e;
    build(done_idx);
    idle_e = exp_q[done_idx];
    idle_e.ocup = 1'b0; idle_e.fin = 1'b0; idle_e.valid = 1'b0;
    for (int i = 0; i < idle_n; i++) exp_q.push_back(idle_e);
    rst_e.addr = '0; rst_e.instr = '0; rst_e.ocup = 1'b0; rst_e.fin = 1'b0;
    rst_e.valid = 1'b0; rst_e.leido = '0;
    inicio = 1'b1;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      inicio  = 1'b0;
      abortar = 1'b0;
      rst     = 1'b0;
      e = (stop_c >= 0 && c > stop_c) ? rst_e : exp_q[c];
      chk_obs(c, e);
      if (c == stop_c) begin
        if (by_rst) rst = 1'b1;
        else abortar = 1'b1;
      end
      if (by_rst && stop_c >= 0 && c == stop_c + 1) rst = 1'b1;
      if (c == ign_c || (ign_done && c == done_idx)) inicio = 1'b1;
    end
    if (stop_c >= 0) begin
      mdl_word  = '0;
      mdl_leido = '0;
    end
  endtask

  initial begin
    rst = 1'b1; inicio = 1'b0; abortar = 1'b0;
    sal_fixed = 1'b0; sal_const = '0;
    for (int i = 0; i < 32; i++) rom[i] = '0;
    mdl_word = '0; mdl_leido = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rom_addr", 32'(rom_addr), 32'd0);
    chk("reset instruccion", 32'(instruccion), 32'd0);
    chk("reset ocupado", 32'(ocupado), 32'd0);
    chk("reset fin", 32'(fin), 32'd0);
    chk("reset dato_valido", 32'(dato_valido), 32'd0);
    chk("reset dato_leido", dato_leido, 32'd0);

    // Single write with HALT
    rom[0] = 21'b00010_00111_0_010_00011_1_1;
    for (int k = 1; k < DEPTH; k++) rom[k] = IW'($urandom);
    run(-1, 1'b0, -1, 1'b0, 3);

    // Read capture with a constant datapath result
    rom[0] = 21'b00010_00111_0_010_00011_1_0;
    rom[1] = 21'b00000_00000_0_000_00011_0_1;
    sal_fixed = 1'b1; sal_const = 32'hA5A5_0007;
    run(-1, 1'b0, -1, 1'b0, 3);
    chk("read capture dato_leido", dato_leido, 32'hA5A5_0007);
    sal_fixed = 1'b0;

    // End of ROM, with ignored starts while busy and in the fin cycle
    for (int k = 0; k < DEPTH; k++) rom[k] = IW'($urandom) & ~21'd1;
    run(-1, 1'b0, 10, 1'b1, 3);
    chk("end of rom pc held", 32'(rom_addr), 32'd20);

    // Abort in the last HOLD cycle of a read (word 3), then a fresh start
    for (int k = 0; k < DEPTH; k++) rom[k] = IW'($urandom) & ~21'd1;
    rom[3][1] = 1'b0;
    run(23, 1'b0, -1, 1'b0, 3);
    for (int k = 0; k < DEPTH; k++) begin
      rom[k] = IW'($urandom);
      rom[k][0] = ($urandom_range(0, 4) == 0);
    end
    run(-1, 1'b0, -1, 1'b0, 2);

    // Synchronous reset held for two cycles in the middle of a HOLD
    for (int k = 0; k < DEPTH; k++) rom[k] = IW'($urandom) & ~21'd1;
    run(8, 1'b1, -1, 1'b0, 3);

    // Random programs with random HALT placement
    repeat (6) begin
      for (int k = 0; k < DEPTH; k++) begin
        rom[k] = IW'($urandom);
        rom[k][0] = ($urandom_range(0, 5) == 0);
      end
      run(-1, 1'b0, -1, 1'b0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
